// File: rtl/univ_shift_pkg.sv
// Shared encodings for the universal shift register: operation modes and FSM states.
package univ_shift_pkg;

  typedef enum logic [2:0] {
    MODE_NOP  = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_ASR  = 3'b110,
    MODE_RSVD = 3'b111
  } mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/univ_shift_reg_shift_step.sv
// One-position combinational shifter: next register value and the bit pushed out.
module shift_step
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_q,
  input  logic             i_sin,
  input  mode_e            i_mode,
  output logic [WIDTH-1:0] o_q,
  output logic             o_out
);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; otherwise a latch is inferred.
    o_q   = i_q;
    o_out = 1'b0;
    case (i_mode)
      MODE_SHL: begin o_q = {i_q[WIDTH-2:0], i_sin};      o_out = i_q[WIDTH-1]; end
      MODE_SHR: begin o_q = {i_sin, i_q[WIDTH-1:1]};      o_out = i_q[0];       end
      MODE_ROL: begin o_q = {i_q[WIDTH-2:0], i_q[WIDTH-1]}; o_out = i_q[WIDTH-1]; end
      MODE_ROR: begin o_q = {i_q[0], i_q[WIDTH-1:1]};     o_out = i_q[0];       end
      MODE_ASR: begin o_q = {i_q[WIDTH-1], i_q[WIDTH-1:1]}; o_out = i_q[0];     end
      default:  ;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load plus multi-cycle shift/rotate, one position per clock.
module univ_shift_reg
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Clr,
  input  logic             Set,
  input  logic             Hold,
  input  logic             Start,
  input  logic [2:0]       Mode,
  input  logic [AMT_W-1:0] Amt,
  input  logic [WIDTH-1:0] D,
  input  logic             Sin,
  output logic [WIDTH-1:0] Q,
  output logic             Sout,
  output logic             Busy,
  output logic             Done
);

  localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH);
  localparam logic [AMT_W-1:0] AMT_ONE = AMT_W'(1);

  state_e           r_state;
  mode_e            r_mode;
  logic [AMT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_q;
  logic             r_sout;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_next_q;
  logic             w_out;
  logic [AMT_W-1:0] w_amt_sat;
  mode_e            w_mode_in;

  assign w_mode_in = mode_e'(Mode);
  assign w_amt_sat = (Amt > AMT_MAX) ? AMT_MAX : Amt;

  // Shifter sees only the latched mode, so Mode changes mid-operation are harmless.
  shift_step #(.WIDTH(WIDTH)) u_step (
    .i_q    (r_q),
    .i_sin  (Sin),
    .i_mode (r_mode),
    .o_q    (w_next_q),
    .o_out  (w_out)
  );

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_NOP;
      r_cnt   <= '0;
      r_q     <= '0;
      r_sout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (Clr || Set) begin
      r_q     <= Clr ? '0 : '1;
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (!Hold) begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (Start) begin
            case (w_mode_in)
              MODE_LOAD: begin
                r_q    <= D;
                r_done <= 1'b1;
              end
              MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR: begin
                if (w_amt_sat == '0) begin
                  r_done <= 1'b1;
                end else begin
                  r_mode  <= w_mode_in;
                  r_cnt   <= w_amt_sat;
                  r_state <= ST_SHIFT;
                  r_busy  <= 1'b1;
                end
              end
              default: r_done <= 1'b1;
            endcase
          end
        end
        ST_SHIFT: begin
          r_q    <= w_next_q;
          r_sout <= w_out;
          r_cnt  <= r_cnt - AMT_ONE;
          if (r_cnt == AMT_ONE) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign Q    = r_q;
  assign Sout = r_sout;
  assign Busy = r_busy;
  assign Done = r_done;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=8); hand-computed expectations checked by assertions.
module tb_univ_shift_reg;
  import univ_shift_pkg::*;

  localparam int WIDTH = 8;
  localparam int AMT_W = 4;

  logic             Clk = 1'b0;
  logic             Rst_n, Clr, Set, Hold, Start, Sin;
  logic [2:0]       Mode;
  logic [AMT_W-1:0] Amt;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic             Sout, Busy, Done;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_n;

  univ_shift_reg #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Clr(Clr), .Set(Set), .Hold(Hold), .Start(Start),
    .Mode(Mode), .Amt(Amt), .D(D), .Sin(Sin),
    .Q(Q), .Sout(Sout), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are read there too, half a cycle after the rising edge.
  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic load(input logic [WIDTH-1:0] val);
    Start = 1'b1; Mode = MODE_LOAD; D = val;
    tick();
    Start = 1'b0;
    tick();
  endtask

  task automatic start_op(input mode_e m, input logic [AMT_W-1:0] a, input logic s);
    Start = 1'b1; Mode = m; Amt = a; Sin = s;
    tick();
    Start = 1'b0;
  endtask

  // Counts consecutive Busy cycles starting right after the Start edge, bounded.
  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!Busy) break;
      n++;
      tick();
    end
  endtask

  initial begin
    Rst_n = 1'b0; Clr = 1'b0; Set = 1'b0; Hold = 1'b0; Start = 1'b0;
    Mode = MODE_NOP; Amt = '0; D = '0; Sin = 1'b0;
    tick(); tick();
    check("rst_q", Q, 8'h00);
    check("rst_sout", Sout, 1'b0);
    check("rst_busy", Busy, 1'b0);
    check("rst_done", Done, 1'b0);
    Rst_n = 1'b1;
    tick();

    // Parallel load
    Start = 1'b1; Mode = MODE_LOAD; D = 8'hB4;
    tick();
    Start = 1'b0;
    check("load_q", Q, 8'hB4);
    check("load_done", Done, 1'b1);
    check("load_busy", Busy, 1'b0);
    tick();
    check("load_done_clr", Done, 1'b0);
    check("load_busy2", Busy, 1'b0);

    // Asynchronous reset mid-cycle, with a shift in progress
    load(8'hA5);
    check("a5_q", Q, 8'hA5);
    start_op(MODE_SHL, 4'd3, 1'b1);
    check("pre_rst_busy", Busy, 1'b1);
    #2 Rst_n = 1'b0;
    #1;
    check("async_rst_q", Q, 8'h00);
    check("async_rst_busy", Busy, 1'b0);
    check("async_rst_done", Done, 1'b0);
    @(negedge Clk);
    Rst_n = 1'b1;
    tick();
    check("post_rst_done", Done, 1'b0);
    check("post_rst_busy", Busy, 1'b0);
    tick();
    check("post_rst_done2", Done, 1'b0);

    // SHL by 3 with Sin=1 from 0x81
    load(8'h81);
    start_op(MODE_SHL, 4'd3, 1'b1);
    check("shl_start_q", Q, 8'h81);
    check("shl_start_busy", Busy, 1'b1);
    tick();
    check("shl_q1", Q, 8'h03);
    check("shl_sout1", Sout, 1'b1);
    check("shl_busy1", Busy, 1'b1);
    tick();
    check("shl_q2", Q, 8'h07);
    check("shl_sout2", Sout, 1'b0);
    check("shl_busy2", Busy, 1'b1);
    tick();
    check("shl_q3", Q, 8'h0F);
    check("shl_sout3", Sout, 1'b0);
    check("shl_busy3", Busy, 1'b0);
    check("shl_done", Done, 1'b1);
    tick();
    check("shl_done_clr", Done, 1'b0);
    check("shl_sout_hold", Sout, 1'b0);

    // ROR by WIDTH returns the original value
    load(8'h3C);
    start_op(MODE_ROR, 4'd8, 1'b0);
    count_busy(busy_n);
    check("ror8_busy_cycles", busy_n, 8);
    check("ror8_q", Q, 8'h3C);
    check("ror8_done", Done, 1'b1);
    tick();

    // Amount above WIDTH saturates: ROL by 15 acts as ROL by 8
    load(8'h96);
    start_op(MODE_ROL, 4'd15, 1'b0);
    count_busy(busy_n);
    check("rol_sat_busy_cycles", busy_n, 8);
    check("rol_sat_q", Q, 8'h96);
    tick();

    // ASR by 2 keeps the sign bit
    load(8'h90);
    start_op(MODE_ASR, 4'd2, 1'b0);
    tick();
    check("asr_q1", Q, 8'hC8);
    tick();
    check("asr_q2", Q, 8'hE4);
    check("asr_done", Done, 1'b1);
    tick();

    // SHR by 4 with a 3-cycle Hold after the second shift
    load(8'hF0);
    start_op(MODE_SHR, 4'd4, 1'b0);
    busy_n = Busy ? 1 : 0;
    tick();
    check("shr_q1", Q, 8'h78);
    busy_n += Busy ? 1 : 0;
    tick();
    check("shr_q2", Q, 8'h3C);
    busy_n += Busy ? 1 : 0;
    Hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("shr_hold_q", Q, 8'h3C);
      check("shr_hold_done", Done, 1'b0);
      busy_n += Busy ? 1 : 0;
    end
    Hold = 1'b0;
    tick();
    check("shr_q3", Q, 8'h1E);
    busy_n += Busy ? 1 : 0;
    tick();
    check("shr_q4", Q, 8'h0F);
    check("shr_done", Done, 1'b1);
    check("shr_busy_total", busy_n, 7);
    tick();

    // SHR with Sin=1 and the Sout of the low bit
    load(8'h03);
    start_op(MODE_SHR, 4'd1, 1'b1);
    tick();
    check("shr_sin_q", Q, 8'h81);
    check("shr_sin_sout", Sout, 1'b1);
    tick();

    // Start while busy is ignored; Clr+Set aborts with no Done
    load(8'h5A);
    start_op(MODE_SHL, 4'd5, 1'b0);
    tick();
    check("abort_q1", Q, 8'hB4);
    check("abort_sout1", Sout, 1'b0);
    Start = 1'b1; Mode = MODE_LOAD; D = 8'hFF;
    tick();
    Start = 1'b0; Mode = MODE_NOP;
    check("ignored_start_q", Q, 8'h68);
    check("abort_sout2", Sout, 1'b1);
    Clr = 1'b1; Set = 1'b1;
    tick();
    Clr = 1'b0; Set = 1'b0;
    check("clrset_q", Q, 8'h00);
    check("clrset_busy", Busy, 1'b0);
    check("clrset_done", Done, 1'b0);
    check("clrset_sout", Sout, 1'b1);
    tick();
    check("clrset_no_done", Done, 1'b0);
    check("clrset_q_stays", Q, 8'h00);

    // Set alone fills with ones
    Set = 1'b1;
    tick();
    Set = 1'b0;
    check("set_q", Q, 8'hFF);

    // NOP, Amt=0 and reserved mode complete immediately; Hold freezes Done
    start_op(MODE_NOP, 4'd3, 1'b0);
    check("nop_done", Done, 1'b1);
    check("nop_q", Q, 8'hFF);
    Hold = 1'b1;
    tick();
    check("hold_done_frozen", Done, 1'b1);
    Hold = 1'b0;
    tick();
    check("hold_done_clr", Done, 1'b0);
    start_op(MODE_SHL, 4'd0, 1'b0);
    check("amt0_done", Done, 1'b1);
    check("amt0_busy", Busy, 1'b0);
    check("amt0_q", Q, 8'hFF);
    tick();
    start_op(MODE_RSVD, 4'd2, 1'b0);
    check("rsvd_done", Done, 1'b1);
    check("rsvd_busy", Busy, 1'b0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width (WIDTH >= 2).
REQ-002 SHALL have parameter AMT_W, default $clog2(WIDTH)+1, shift-amount width.
REQ-003 SHALL have one clock and an asynchronous, active-low reset; all other inputs are synchronous to Clk.
REQ-004 Clk  in  1  clock; all state changes on rising edge.
REQ-005 Rst_n  in  1  asynchronous active-low reset.
REQ-006 Clr  in  1  synchronous clear of Q.
REQ-007 Set  in  1  synchronous set of Q to all ones.
REQ-008 Hold  in  1  freeze all registers.
REQ-009 Start  in  1  begin the operation selected by Mode.
REQ-010 Mode  in  3  operation: 000 NOP, 001 LOAD, 010 SHL, 011 SHR, 100 ROL, 101 ROR, 110 ASR, 111 reserved (treated as NOP).
REQ-011 Amt  in  AMT_W  shift count, 0..WIDTH.
REQ-012 D  in  WIDTH  parallel load data.
REQ-013 Sin  in  1  serial fill bit for SHL/SHR.
REQ-014 Q  out  WIDTH  register contents.
REQ-015 Sout  out  1  bit shifted out on the most recent shift edge.
REQ-016 Busy  out  1  multi-cycle shift in progress.
REQ-017 Done  out  1  one-cycle completion pulse.

Function
REQ-018 Priority per edge SHALL be Clr > Set > Hold > Start/shift progress.
REQ-019 Clr or Set SHALL abort any operation: state IDLE, Busy=0, Done=0, Sout unchanged.
REQ-020 Hold=1 SHALL freeze Q, Sout, state, counter, Busy and Done.
REQ-021 FSM states: IDLE, SHIFT.
REQ-022 IDLE + Start + LOAD: Q<=D on that edge; Done=1 for the following cycle; Busy stays 0.
REQ-023 IDLE + Start + NOP/reserved: Q unchanged; Done=1 for the following cycle.
REQ-024 IDLE + Start + shift mode with Amt=0: Q unchanged; Done=1 for the following cycle.
REQ-025 IDLE + Start + shift mode with Amt>0 SHALL: latch Mode, load counter with min(Amt, WIDTH), go to SHIFT, and set Busy=1; Q is unchanged on that edge.
REQ-026 In SHIFT, each edge SHALL shift Q one position and decrement the counter.
REQ-027 On the edge where the counter goes 1->0, the FSM SHALL enter IDLE with Busy=0 and Done=1 for one cycle; Busy is therefore high for exactly k cycles for k shifts.
REQ-028 Amt > WIDTH SHALL saturate to WIDTH.
REQ-029 Start while Busy=1 SHALL be ignored; Mode, Amt and Sin changes during SHIFT SHALL not affect the latched mode (Sin is sampled each shift edge).
REQ-030 Shift rules:
- SHL: Q<={Q[W-2:0],Sin}, Sout<=Q[W-1]
- SHR: Q<={Sin,Q[W-1:1]}, Sout<=Q[0]
- ROL: Q<={Q[W-2:0],Q[W-1]}, Sout<=Q[W-1]
- ROR: Q<={Q[0],Q[W-1:1]}, Sout<=Q[0]
- ASR: Q<={Q[W-1],Q[W-1:1]}, Sout<=Q[0]
REQ-031 A rotate by WIDTH SHALL return Q to its original value.
REQ-032 Sout SHALL change only on shift edges, Clr/Set excepted as per REQ-019.

Reset
REQ-033 Rst_n=0 SHALL immediately, without a clock edge, force Q=0, Sout=0, Busy=0, Done=0, state IDLE, counter 0.
REQ-034 An operation in progress when reset asserts SHALL be discarded; no Done follows reset release.
REQ-035 Reset SHALL override Clr, Set, Hold and Start.

Structure
REQ-036 Package univ_shift_pkg SHALL hold the Mode encodings and the FSM state encoding.
REQ-037 The one-position shifter SHALL be a combinational sub-module shift_step (inputs Q, Sin, mode; outputs next Q and out bit).
REQ-038 Control (FSM, counter, priority) SHALL live in univ_shift_reg.

Verification (WIDTH=8)
REQ-039 Q=8'hA5, pull Rst_n low mid-cycle -> Q=8'h00, Busy=0, Done=0 before the next edge.
REQ-040 Start, LOAD, D=8'hB4 -> Q=8'hB4 after 1 edge, Done high 1 cycle, Busy never high.
REQ-041 Q=8'h81, Start, SHL, Amt=3, Sin=1 -> Q=03, 07, 0F on successive edges; Sout=1,0,0; Busy 3 cycles, then Done 1 cycle.
REQ-042 Q=8'h3C, ROR, Amt=8 -> Q=8'h3C at Done after 8 Busy cycles; then Q=8'h90, ASR, Amt=2 -> Q=8'hE4.
REQ-043 Q=8'hF0, SHR, Amt=4, Sin=0, Hold for 3 cycles after the 2nd shift -> Q holds 8'h3C, resumes, final Q=8'h0F; Busy 7 cycles total.
REQ-044 Clr and Set together during SHIFT -> Q=8'h00, Busy=0, no Done; a Start pulse while Busy -> ignored, Q sequence unchanged.
